// File: rtl/lebug_pkg.sv
// Shared types and the reduction operator used by both the tree nodes and the frame accumulator.
package lebug_pkg;

   typedef enum logic [1:0] {
      RED_SUM  = 2'b00,
      RED_MAX  = 2'b01,
      RED_MIN  = 2'b10,
      RED_PASS = 2'b11
   } red_op_t;

   typedef enum logic {
      S_IDLE,
      S_ACCUM
   } fsm_state_t;

   // Operands are sign-extended to this width, so any DATA_WIDTH up to 64 compares correctly
   localparam int RED_W = 64;

   typedef struct packed {
      logic    valid;
      logic    eof;
      red_op_t op;
      logic    acc_mode;
   } side_t;

   // Ties keep operand a (lower lane, or the running accumulator); PASS keeps a
   function automatic logic signed [RED_W-1:0] red_combine(
      input red_op_t                 op,
      input logic signed [RED_W-1:0] a,
      input logic signed [RED_W-1:0] b
   );
      logic signed [RED_W-1:0] r;
      r = a;
      case (op)
         RED_SUM: r = a + b;
         RED_MAX: if (b > a) r = b;
         RED_MIN: if (b < a) r = b;
         default: r = a;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/reduce_tree_stage.sv
// One registered level of the reduction tree: pairs adjacent lanes and carries the sideband along.
module reduce_tree_stage
   import lebug_pkg::*;
#(
   parameter int LANES_IN   = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  side_t                                 side_in,
   input  logic [LANES_IN*DATA_WIDTH-1:0]        lanes_in,
   output side_t                                 side_out,
   output logic [(LANES_IN/2)*DATA_WIDTH-1:0]    lanes_out
);

   localparam int LANES_OUT = LANES_IN / 2;

   logic [LANES_OUT*DATA_WIDTH-1:0] lanes_nxt;

   always_comb begin
      lanes_nxt = '0;
      for (int i = 0; i < LANES_OUT; i++) begin
         lanes_nxt[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(red_combine(
            side_in.op,
            RED_W'($signed(lanes_in[(2*i)*DATA_WIDTH +: DATA_WIDTH])),
            RED_W'($signed(lanes_in[(2*i+1)*DATA_WIDTH +: DATA_WIDTH]))));
      end
   end

   // NOTE: state is updated with <= so every stage samples the previous stage's old value on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         side_out  <= '0;
         lanes_out <= '0;
      end else begin
         side_out <= side_in;
         if (side_in.valid) lanes_out <= lanes_nxt;
      end
   end

endmodule

// File: rtl/vector_reduce_unit.sv
// Reduces each N-lane vector to a scalar through a pipelined tree, optionally accumulating over a frame.
module vector_reduce_unit
   import lebug_pkg::*;
#(
   parameter int N          = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid_in,
   input  logic                  eof_in,
   input  logic [DATA_WIDTH-1:0] vector_in [N-1:0],
   input  logic [1:0]            op_in,
   input  logic                  acc_mode_in,
   output logic                  valid_out,
   output logic                  eof_out,
   output logic [DATA_WIDTH-1:0] scalar_out,
   output logic                  frame_open
);

   localparam int LAT    = $clog2(N) + 1;
   localparam int STAGES = LAT - 1;

   // Frame-level op/mode latch on the input side
   logic    in_frame_q;
   red_op_t op_q;
   logic    mode_q;

   side_t                   side0;
   logic [N*DATA_WIDTH-1:0] lanes0;

   always_comb begin
      side0.valid    = valid_in;
      side0.eof      = valid_in & eof_in;
      side0.op       = in_frame_q ? op_q : red_op_t'(op_in);
      side0.acc_mode = in_frame_q ? mode_q : acc_mode_in;
      lanes0         = '0;
      for (int i = 0; i < N; i++) lanes0[i*DATA_WIDTH +: DATA_WIDTH] = vector_in[i];
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_tree
      localparam int LIN = N >> k;
      side_t                            side_q;
      logic [(LIN/2)*DATA_WIDTH-1:0]    lanes_q;
      if (k == 0) begin : g_first
         reduce_tree_stage #(.LANES_IN(LIN), .DATA_WIDTH(DATA_WIDTH)) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .side_in   (side0),
            .lanes_in  (lanes0),
            .side_out  (side_q),
            .lanes_out (lanes_q)
         );
      end else begin : g_next
         reduce_tree_stage #(.LANES_IN(LIN), .DATA_WIDTH(DATA_WIDTH)) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .side_in   (g_tree[k-1].side_q),
            .lanes_in  (g_tree[k-1].lanes_q),
            .side_out  (side_q),
            .lanes_out (lanes_q)
         );
      end
   end

   side_t                 t_side;
   logic [DATA_WIDTH-1:0] t_res;
   assign t_side = g_tree[STAGES-1].side_q;
   assign t_res  = g_tree[STAGES-1].lanes_q;

   fsm_state_t            state_q, state_d;
   logic [DATA_WIDTH-1:0] acc_q, acc_d, combined;
   logic [DATA_WIDTH-1:0] scalar_d;
   logic                  valid_d, eof_d;

   // NOTE: every always_comb output gets a default first, so no path can leave one unassigned and infer a latch.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      valid_d  = 1'b0;
      eof_d    = 1'b0;
      scalar_d = scalar_out;
      combined = DATA_WIDTH'(red_combine(t_side.op, RED_W'($signed(acc_q)), RED_W'($signed(t_res))));
      case (state_q)
         S_IDLE: begin
            if (t_side.valid) begin
               if (!t_side.acc_mode || t_side.eof) begin
                  valid_d  = 1'b1;
                  eof_d    = t_side.eof;
                  scalar_d = t_res;
               end else begin
                  acc_d   = t_res;
                  state_d = S_ACCUM;
               end
            end
         end
         S_ACCUM: begin
            if (t_side.valid) begin
               if (t_side.eof) begin
                  valid_d  = 1'b1;
                  eof_d    = 1'b1;
                  scalar_d = combined;
                  state_d  = S_IDLE;
               end else begin
                  acc_d = combined;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         acc_q      <= '0;
         valid_out  <= 1'b0;
         eof_out    <= 1'b0;
         scalar_out <= '0;
         in_frame_q <= 1'b0;
         op_q       <= RED_SUM;
         mode_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         valid_out  <= valid_d;
         eof_out    <= eof_d;
         scalar_out <= scalar_d;
         if (valid_in) begin
            in_frame_q <= !eof_in;
            op_q       <= side0.op;
            mode_q     <= side0.acc_mode;
         end
      end
   end

   assign frame_open = (state_q == S_ACCUM);

endmodule

// File: tb/tb_vector_reduce_unit.sv
// Directed bench for vector_reduce_unit (N=8, DATA_WIDTH=32) with hand-computed expected scalars.
module tb_vector_reduce_unit;

   localparam int N   = 8;
   localparam int DW  = 32;
   localparam int LAT = 4;

   typedef int vec_t [8];
   typedef struct {
      int          cy;
      logic [31:0] val;
      logic        eof;
   } ev_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          valid_in, eof_in, acc_mode_in;
   logic [DW-1:0] vector_in [N-1:0];
   logic [1:0]    op_in;
   logic          valid_out, eof_out, frame_open;
   logic [DW-1:0] scalar_out;

   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;
   int  fo_cnt = 0;
   int  bad_eof = 0;
   ev_t obs [$];
   ev_t exp_q [$];

   vector_reduce_unit #(.N(N), .DATA_WIDTH(DW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .valid_in    (valid_in),
      .eof_in      (eof_in),
      .vector_in   (vector_in),
      .op_in       (op_in),
      .acc_mode_in (acc_mode_in),
      .valid_out   (valid_out),
      .eof_out     (eof_out),
      .scalar_out  (scalar_out),
      .frame_open  (frame_open)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valid_out) obs.push_back('{cyc, scalar_out, eof_out});
      if (!valid_out && eof_out) bad_eof++;
      if (frame_open) fo_cnt++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [1:0] op, input logic mode, input logic eof, input vec_t v, output int s);
      @(negedge clk);
      valid_in    = 1'b1;
      eof_in      = eof;
      op_in       = op;
      acc_mode_in = mode;
      for (int i = 0; i < N; i++) vector_in[i] = v[i];
      s = cyc + 1;
   endtask

   task automatic idle();
      @(negedge clk);
      valid_in = 1'b0;
      eof_in   = 1'b0;
   endtask

   task automatic expect_out(input logic [31:0] val, input logic eof, input int cy);
      exp_q.push_back('{cy, val, eof});
   endtask

   task automatic flush_and_compare(input string tag);
      int n;
      idle();
      repeat (8) @(negedge clk);
      check({tag, "_n"}, obs.size(), exp_q.size());
      n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_val%0d", tag, i), obs[i].val, exp_q[i].val);
         check($sformatf("%s_eof%0d", tag, i), obs[i].eof, exp_q[i].eof);
         check($sformatf("%s_cyc%0d", tag, i), obs[i].cy, exp_q[i].cy);
      end
      if (exp_q.size() > 0) check({tag, "_hold"}, scalar_out, exp_q[exp_q.size()-1].val);
      obs.delete();
      exp_q.delete();
   endtask

   vec_t v_seq, v_mix, v_one, v_min8, v_tens, v_b;
   int   s1, s2, s3, s4;

   initial begin
      v_seq  = '{1, 2, 3, 4, 5, 6, 7, 8};
      v_mix  = '{-5, 3, 3, -1, 0, 7, -9, 2};
      v_one  = '{1, 1, 1, 1, 1, 1, 1, 1};
      v_min8 = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
      v_tens = '{10, 20, 30, 40, 50, 60, 70, 80};
      v_b    = '{4, -2, 6, 1, -7, 3, 0, 5};

      rst_n = 1'b0;
      valid_in = 1'b0;
      eof_in = 1'b0;
      op_in = 2'b00;
      acc_mode_in = 1'b0;
      for (int i = 0; i < N; i++) vector_in[i] = '0;
      #1;
      check("rst_valid", valid_out, 0);
      check("rst_eof", eof_out, 0);
      check("rst_scalar", scalar_out, 0);
      check("rst_open", frame_open, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Per-vector SUM, eof_out follows eof_in
      send(2'b00, 1'b0, 1'b0, v_seq, s1);
      send(2'b00, 1'b0, 1'b1, v_seq, s2);
      expect_out(36, 1'b0, s1 + LAT - 1);
      expect_out(36, 1'b1, s2 + LAT - 1);
      flush_and_compare("sum_m0");

      // MAX, MIN, PASS on consecutive single-vector frames
      send(2'b01, 1'b0, 1'b1, v_mix, s1);
      send(2'b10, 1'b0, 1'b1, v_mix, s2);
      send(2'b11, 1'b0, 1'b1, v_mix, s3);
      expect_out(7, 1'b1, s1 + LAT - 1);
      expect_out(-9, 1'b1, s2 + LAT - 1);
      expect_out(-5, 1'b1, s3 + LAT - 1);
      flush_and_compare("mmp_m0");

      // Three-vector SUM frame
      fo_cnt = 0;
      send(2'b00, 1'b1, 1'b0, v_one, s1);
      send(2'b00, 1'b1, 1'b0, v_one, s2);
      send(2'b00, 1'b1, 1'b1, v_one, s3);
      expect_out(24, 1'b1, s3 + LAT - 1);
      flush_and_compare("acc3");
      check("acc3_open_cycles", fo_cnt, 2);

      // Accumulated SUM wraps modulo 2^32
      fo_cnt = 0;
      send(2'b00, 1'b1, 1'b0, v_min8, s1);
      send(2'b00, 1'b1, 1'b1, v_min8, s2);
      expect_out(32'h0000_0000, 1'b1, s2 + LAT - 1);
      flush_and_compare("wrap");
      check("wrap_open_cycles", fo_cnt, 1);

      // Frame A keeps its first op/mode, frame B follows without a bubble
      send(2'b01, 1'b1, 1'b0, v_seq, s1);
      send(2'b00, 1'b0, 1'b1, v_tens, s2);
      send(2'b10, 1'b1, 1'b1, v_b, s3);
      expect_out(80, 1'b1, s2 + LAT - 1);
      expect_out(-7, 1'b1, s3 + LAT - 1);
      flush_and_compare("b2b");

      // Reset with an open frame and vectors in flight
      send(2'b00, 1'b1, 1'b0, v_one, s1);
      send(2'b00, 1'b1, 1'b0, v_one, s2);
      send(2'b00, 1'b1, 1'b0, v_one, s3);
      send(2'b00, 1'b1, 1'b1, v_one, s4);
      idle();
      check("pre_rst_open", frame_open, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", valid_out, 0);
      check("mid_rst_eof", eof_out, 0);
      check("mid_rst_scalar", scalar_out, 0);
      check("mid_rst_open", frame_open, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      flush_and_compare("post_rst_quiet");

      // First vector after reset opens a fresh frame with its own op
      send(2'b01, 1'b0, 1'b1, v_seq, s1);
      expect_out(8, 1'b1, s1 + LAT - 1);
      flush_and_compare("post_rst_max");

      check("eof_without_valid", bad_eof, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
